// File: rtl/onchip_memory_test_master.sv
// onchip_memory_test_master
//   Avalon-MM bring-up / self-test master for the single-port on-chip RAM.
//   On start it writes COUNT pattern words from BASE, reads every word back,
//   compares each one against the regenerated pattern and reports the result.
//
// Configuration macro:
//   MEMTEST_LFSR_PATTERN_EN  defined   -> pattern from a 32-bit Galois LFSR
//                                         (taps 0x80200003), seeded with seed
//                                         (0 forced to 1), advanced per beat.
//                            undefined -> pattern = zero-extended address XOR seed.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 1-cycle request, honoured only in IDLE or DONE
//   base_addr/word_count  first word address / number of words (0 is legal)
//   seed                  pattern seed
//   busy, done, pass      status; pass is only meaningful while done is high
//   err_count             saturating mismatch count
//   first_fail_addr       address of the first mismatch, 0 if none
//   avm_*                 Avalon-MM master interface (word addressed)
module onchip_memory_test_master #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   word_count,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_fail_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   ffa_q, ffa_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
`ifdef MEMTEST_LFSR_PATTERN_EN
  logic [31:0]         lfsr_q, lfsr_d;
`endif

  logic [ADDR_W-1:0]   addr_cur;
  logic [DATA_W-1:0]   exp_word;
  logic                last_word;
  logic                rd_sample;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef MEMTEST_LFSR_PATTERN_EN
  // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
  function automatic logic [31:0] lfsr_load(input logic [DATA_W-1:0] s);
    logic [31:0] v;
    v = 32'(s);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  // Right-shifting Galois form: feedback bit is the LSB shifted out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'd0);
  endfunction
`endif

  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign addr_cur  = base_q + idx_q;
  assign last_word = ((idx_q + ADDR_W'(1)) == count_q);
  assign rd_sample = (lat_q == LAT_W'(READ_LATENCY));

`ifdef MEMTEST_LFSR_PATTERN_EN
  assign exp_word = DATA_W'(lfsr_q);
`else
  assign exp_word = DATA_W'(addr_cur) ^ seed_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      seed_q  <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      ffa_q   <= '0;
      lat_q   <= '0;
`ifdef MEMTEST_LFSR_PATTERN_EN
      lfsr_q  <= 32'd1;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      seed_q  <= seed_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      lat_q   <= lat_d;
`ifdef MEMTEST_LFSR_PATTERN_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    seed_d    = seed_q;
    idx_d     = idx_q;
    err_d     = err_q;
    ffa_d     = ffa_q;
    lat_d     = lat_q;
`ifdef MEMTEST_LFSR_PATTERN_EN
    lfsr_d    = lfsr_q;
`endif
    avm_read  = 1'b0;
    avm_write = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = word_count;
          seed_d  = seed;
          idx_d   = '0;
          err_d   = '0;
          ffa_d   = '0;
          lat_d   = '0;
`ifdef MEMTEST_LFSR_PATTERN_EN
          lfsr_d  = lfsr_load(seed);
`endif
          // An empty test has nothing to write or read: report immediately.
          state_d = (word_count == '0) ? S_DONE : S_WRITE;
        end
      end

      S_WRITE: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          if (last_word) begin
            // Rewind index and pattern so the read pass regenerates the same words.
            idx_d   = '0;
`ifdef MEMTEST_LFSR_PATTERN_EN
            lfsr_d  = lfsr_load(seed_q);
`endif
            state_d = S_RD_REQ;
          end else begin
            idx_d  = idx_q + ADDR_W'(1);
`ifdef MEMTEST_LFSR_PATTERN_EN
            lfsr_d = lfsr_step(lfsr_q);
`endif
          end
        end
      end

      S_RD_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          lat_d   = LAT_W'(1);
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        // lat_q counts edges since the accept edge; data is valid on the
        // READ_LATENCY-th one.
        if (rd_sample) begin
          if (avm_readdata != exp_word) begin
            err_d = sat_inc16(err_q);
            if (err_q == 16'd0) begin
              ffa_d = addr_cur;
            end
          end
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
`ifdef MEMTEST_LFSR_PATTERN_EN
            lfsr_d  = lfsr_step(lfsr_q);
`endif
            state_d = S_RD_REQ;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address and data are gated to 0 outside an active request so that the
  // bus is quiet in IDLE/DONE and immediately after reset.
  assign avm_chipselect  = avm_read | avm_write;
  assign avm_byteenable  = {BE_W{avm_chipselect}};
  assign avm_address     = avm_chipselect ? addr_cur : '0;
  assign avm_writedata   = avm_write ? exp_word : '0;

  assign busy            = (state_q == S_WRITE) || (state_q == S_RD_REQ) ||
                           (state_q == S_RD_WAIT);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_q == 16'd0);
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_onchip_memory_test_master.sv
module tb_onchip_memory_test_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [14:0] base_addr;
  logic [14:0] word_count;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [14:0] first_fail_addr;
  logic [14:0] avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  onchip_memory_test_master #(
    .ADDR_W(15),
    .DATA_W(32),
    .READ_LATENCY(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .word_count(word_count),
    .seed(seed),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .first_fail_addr(first_fail_addr),
    .avm_address(avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_read(avm_read),
    .avm_write(avm_write),
    .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // RAM model: latency-1 slave with optional bit flip and scripted stalls.
  logic [31:0] mem [0:32767];
  logic        model_clr;
  logic        flip_en;
  logic [14:0] flip_addr;
  logic        stall_en;
  int          wbeat, rbeat, wstall, rstall;
  logic [14:0] cur_base;
  logic [31:0] cur_seed;

  always_comb begin
    avm_waitrequest = 1'b0;
    if (stall_en) begin
      if (avm_write && wbeat == 1 && wstall != 0) avm_waitrequest = 1'b1;
      if (avm_read  && rbeat == 3 && rstall != 0) avm_waitrequest = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (model_clr) begin
      wbeat  <= 0;
      rbeat  <= 0;
      wstall <= 3;
      rstall <= 3;
    end else begin
      if (avm_write) begin
        if (avm_waitrequest) wstall <= wstall - 1;
        else begin
          mem[avm_address] <= avm_writedata;
          wbeat <= wbeat + 1;
        end
      end
      if (avm_read) begin
        if (avm_waitrequest) rstall <= rstall - 1;
        else begin
          avm_readdata <= mem[avm_address] ^
                          ((flip_en && avm_address == flip_addr) ? 32'd1 : 32'd0);
          rbeat <= rbeat + 1;
        end
      end
    end
  end

  // Bus monitor: every request cycle (stalled ones included) must show the
  // address and pattern for the current beat.
  always @(negedge clk) begin
    logic [14:0] ea;
    if (reset_n && avm_write) begin
      ea = cur_base + 15'(wbeat);
      chk("wr_addr", 32'(avm_address), 32'(ea));
      chk("wr_data", avm_writedata, {17'd0, ea} ^ cur_seed);
      chk("wr_cs_be", {avm_chipselect, avm_byteenable, avm_read}, {1'b1, 4'hF, 1'b0});
    end
    if (reset_n && avm_read) begin
      ea = cur_base + 15'(rbeat);
      chk("rd_addr", 32'(avm_address), 32'(ea));
      chk("rd_cs_be", {avm_chipselect, avm_byteenable, avm_write}, {1'b1, 4'hF, 1'b0});
    end
  end

  task automatic run_test(input string name, input logic [14:0] b, input logic [14:0] n,
                          input logic [31:0] s, input logic fl, input logic [14:0] fa,
                          input logic st, input int exp_errs, input logic [14:0] exp_ffa,
                          input int exp_busy);
    int busy_cyc;
    logic got_done;
    cur_base  = b;
    cur_seed  = s;
    flip_en   = fl;
    flip_addr = fa;
    stall_en  = st;
    model_clr = 1'b1;
    @(negedge clk);
    model_clr  = 1'b0;
    base_addr  = b;
    word_count = n;
    seed       = s;
    start      = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cyc = 0;
    got_done = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
    chk({name, "_done"}, 32'(got_done), 32'd1);
    chk({name, "_busy_cycles"}, busy_cyc, exp_busy);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    chk({name, "_pass"}, 32'(pass), (exp_errs == 0) ? 32'd1 : 32'd0);
    chk({name, "_err_count"}, 32'(err_count), exp_errs);
    chk({name, "_first_fail"}, 32'(first_fail_addr), 32'(exp_ffa));
    chk({name, "_writes"}, wbeat, 32'(n));
    chk({name, "_reads"}, rbeat, 32'(n));
    chk({name, "_bus_idle"}, {avm_read, avm_write, avm_chipselect}, 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    seed       = '0;
    model_clr  = 1'b1;
    flip_en    = 1'b0;
    flip_addr  = '0;
    stall_en   = 1'b0;
    cur_base   = '0;
    cur_seed   = '0;
    avm_readdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_status", {busy, done, pass}, 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_bus", {avm_read, avm_write, avm_chipselect, avm_byteenable}, 32'd0);
    chk("rst_addr_data", 32'(avm_address) | avm_writedata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: basic pass, N=4, latency 1 -> 4 + 4*2 = 12 busy cycles
    run_test("t1", 15'h0000, 15'd4, 32'h0000_1234, 1'b0, '0, 1'b0, 0, 15'h0, 12);
    chk("t1_mem0", mem[0], 32'h0000_1234);
    chk("t1_mem3", mem[3], 32'h0000_1237);

    // 2: bit0 of word 2 flipped on readback
    run_test("t2", 15'h0000, 15'd4, 32'h0000_1234, 1'b1, 15'd2, 1'b0, 1, 15'd2, 12);

    // 3: 3-cycle stalls on write beat 1 and read beat 3 -> 12 + 6
    run_test("t3", 15'h0010, 15'd4, 32'hCAFE_0000, 1'b0, '0, 1'b1, 0, 15'h0, 18);

    // 4: empty test completes on the start edge
    run_test("t4", 15'h0100, 15'd0, 32'h1111_1111, 1'b0, '0, 1'b0, 0, 15'h0, 0);

    // 5: address wrap-around at the top of the space
    run_test("t5", 15'h7FFE, 15'd4, 32'h0F0F_0000, 1'b0, '0, 1'b0, 0, 15'h0, 12);
    chk("t5_mem_wrap0", mem[15'h0000], 32'h0F0F_0000);
    chk("t5_mem_top", mem[15'h7FFF], 32'h0F0F_7FFF);

    // 6: asynchronous reset during write beat 2, then a clean run
    cur_base  = 15'h0020;
    cur_seed  = 32'h5555_0000;
    stall_en  = 1'b0;
    flip_en   = 1'b0;
    model_clr = 1'b1;
    @(negedge clk);
    model_clr  = 1'b0;
    base_addr  = 15'h0020;
    word_count = 15'd6;
    seed       = 32'h5555_0000;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (wbeat == 2 && avm_write) break;
      @(negedge clk);
    end
    chk("t6_reached_beat2", wbeat, 2);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_status", {busy, done, pass}, 32'd0);
    chk("t6_rst_bus", {avm_read, avm_write, avm_chipselect, avm_byteenable}, 32'd0);
    chk("t6_rst_addr_data", 32'(avm_address) | avm_writedata, 32'd0);
    chk("t6_rst_err", 32'(err_count) | 32'(first_fail_addr), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_test("t6", 15'h0040, 15'd3, 32'hA5A5_0000, 1'b0, '0, 1'b0, 0, 15'h0, 9);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
